// File: rtl/instruction_memory_responder_pkg.sv
// Shared MemoryBus types for the instruction memory responder.
// Request and response kinds share the 2-bit type field.
package instruction_memory_responder_pkg;

  localparam int BUS_ID_W = 4;

  typedef logic [63:0]         memory_address_t;
  typedef logic [BUS_ID_W-1:0] bus_id_t;

  typedef enum logic [1:0] {
    bus_read_request  = 2'd0,
    bus_write_request = 2'd1
  } bus_req_t;

  typedef enum logic [1:0] {
    bus_read_response  = 2'd0,
    bus_write_ack      = 2'd1,
    bus_error_response = 2'd2
  } bus_rsp_t;

  typedef struct packed {
    logic [1:0]      kind;
    memory_address_t addr;
    bus_id_t         id;
    logic [63:0]     wdata;
  } memory_request_t;

endpackage

// File: rtl/instruction_memory_responder_if.sv
// MemoryBus request/response channels between initiator and
// the memory-side responder.
interface instruction_memory_responder_if;
  import instruction_memory_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_type;
  memory_address_t req_addr;
  bus_id_t         req_id;
  logic [63:0]     req_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  bus_rsp_t        rsp_type;
  bus_id_t         rsp_id;
  logic [63:0]     rsp_payload;

  modport master (
    output req_valid, req_type, req_addr,
    output req_id, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_type,
    input  rsp_id, rsp_payload
  );

  modport slave (
    input  req_valid, req_type, req_addr,
    input  req_id, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_type,
    output rsp_id, rsp_payload
  );

endinterface

// File: rtl/instruction_memory_responder_bus_request_fifo.sv
// Synchronous FIFO of MemoryRequest entries with occupancy count.
// A push into a full FIFO is taken only alongside a pop.
module bus_request_fifo
  import instruction_memory_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  memory_request_t din,
  input  logic            pop,
  output memory_request_t dout,
  output logic            full,
  output logic            empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  memory_request_t q [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = q[rp];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) q[wp] <= din;
  end

endmodule

// File: rtl/instruction_memory_responder.sv
// Memory-side MemoryBus responder: queued requests, fixed access
// latency, one in-order tagged response per request.
module instruction_memory_responder
  import instruction_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int READ_LATENCY   = 3,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  instruction_memory_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W =
    (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int FCW = $clog2(REQ_FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAT_LOAD =
    CNT_W'(READ_LATENCY - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  memory_request_t  cur;
  memory_request_t  head;
  memory_request_t  req_in;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  logic             rsp_valid_q;
  bus_rsp_t         rsp_type_q;
  bus_id_t          rsp_id_q;
  logic [63:0]      rsp_payload_q;

  logic [63:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             is_rd;
  logic             is_wr;
  logic             op_done;
  logic             wr_en;
  bus_rsp_t         res_type;
  logic [63:0]      res_data;
  logic             unused_lsb;

  assign bus.req_ready = rst_n & ~fifo_full;
  assign push   = bus.req_valid & bus.req_ready;
  assign req_in = '{kind:  bus.req_type,
                    addr:  bus.req_addr,
                    id:    bus.req_id,
                    wdata: bus.req_wdata};
  assign pop = ~fifo_empty &
               ((state == S_IDLE) |
                ((state == S_RESPOND) & bus.rsp_ready));

  bus_request_fifo #(
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (req_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Byte offset is dropped; anything above the word index is an error.
  assign idx        = cur.addr[3 +: IDX_W];
  assign in_range   = ~|cur.addr[63:IDX_W+3];
  assign unused_lsb = ^cur.addr[2:0];
  assign is_rd   = in_range & (cur.kind == bus_read_request);
  assign is_wr   = in_range & (cur.kind == bus_write_request);
  assign op_done = (state == S_ACCESS) & (cnt == '0);
  assign wr_en   = op_done & is_wr;

  always_comb begin
    res_type = bus_error_response;
    res_data = '0;
    unique case (1'b1)
      is_rd: begin
        res_type = bus_read_response;
        res_data = mem[idx];
      end
      is_wr:   res_type = bus_write_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= cur.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cur           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_type_q    <= bus_read_response;
      rsp_id_q      <= '0;
      rsp_payload_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur   <= head;
            cnt   <= LAT_LOAD;
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            rsp_valid_q   <= 1'b1;
            rsp_type_q    <= res_type;
            rsp_id_q      <= cur.id;
            rsp_payload_q <= res_data;
            state         <= S_RESPOND;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESPOND: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!fifo_empty) begin
              cur   <= head;
              cnt   <= LAT_LOAD;
              state <= S_ACCESS;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_type    = rsp_type_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_payload = rsp_payload_q;

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    push |-> (fifo_count < FCW'(REQ_FIFO_DEPTH)) || pop);

  a_rsp_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    rsp_valid_q && !bus.rsp_ready |=>
      rsp_valid_q && $stable(rsp_type_q) &&
      $stable(rsp_id_q) && $stable(rsp_payload_q));

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Randomized self-checking bench for instruction_memory_responder
// against an in-order memory reference model.
module tb_instruction_memory_responder;
  import instruction_memory_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int RLAT  = 3;

  typedef struct {
    logic [1:0]  t;
    logic [63:0] a;
    logic [3:0]  id;
    logic [63:0] d;
  } req_t;

  typedef struct {
    bus_rsp_t    t;
    logic [3:0]  id;
    logic [63:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_memory_responder_if bus();

  instruction_memory_responder #(
    .DEPTH_WORDS    (DEPTH),
    .READ_LATENCY   (RLAT),
    .REQ_FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  req_t        stim_q[$];
  exp_t        exp_q[$];
  logic [63:0] mm [int];
  int          checks = 0;
  int          passes = 0;
  int          acc_rel;
  logic        rdy_rel;

  function automatic exp_t model(req_t r);
    exp_t e;
    int   idx;
    bit   inr;
    e.id = r.id;
    e.p  = '0;
    e.t  = bus_error_response;
    inr  = (r.a < 64'(DEPTH * 8));
    idx  = inr ? int'(r.a / 8) : 0;
    if (inr && r.t == 2'd0) begin
      e.t = bus_read_response;
      e.p = mm.exists(idx) ? mm[idx] : 'x;
    end else if (inr && r.t == 2'd1) begin
      e.t = bus_write_ack;
      mm[idx] = r.d;
    end
    return e;
  endfunction

  // mode: 0 always ready, 1 toggle, 2 random, 3 stalled until hold
  task automatic run(input int mode, input int hold, input int gap);
    int   cyc   = 0;
    int   acc   = 0;
    int   total = stim_q.size();
    bit   have  = 0;
    logic rr;
    req_t cur;
    exp_t e;
    acc_rel = -1;
    rdy_rel = 1'bx;
    while ((acc < total || exp_q.size() != 0) && cyc < 3000) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = cyc[0];
        2:       rr = ($urandom_range(0, 2) != 0);
        default: rr = (cyc >= hold);
      endcase
      if (mode == 3 && cyc == hold) begin
        acc_rel = acc;
        rdy_rel = bus.req_ready;
      end
      if (bus.rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_rsp: got id=%0d type=%0d want none",
                   bus.rsp_id, bus.rsp_type);
        end else begin
          e = exp_q[0];
          if (bus.rsp_type !== e.t || bus.rsp_id !== e.id ||
              bus.rsp_payload !== e.p)
            $display("FAIL rsp: got t=%0d id=%0d p=%h want t=%0d id=%0d p=%h",
                     bus.rsp_type, bus.rsp_id, bus.rsp_payload,
                     e.t, e.id, e.p);
          else
            passes++;
          if (rr) void'(exp_q.pop_front());
        end
      end
      bus.rsp_ready = rr;
      if (!have && stim_q.size() != 0 && $urandom_range(0, 99) >= gap) begin
        cur  = stim_q.pop_front();
        have = 1;
      end
      bus.req_valid = have;
      if (have) begin
        bus.req_type  = cur.t;
        bus.req_addr  = cur.a;
        bus.req_id    = cur.id;
        bus.req_wdata = cur.d;
      end
      if (have && bus.req_ready) begin
        exp_q.push_back(model(cur));
        acc++;
        have = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (acc < total || exp_q.size() != 0)
      $display("FAIL timeout: got acc=%0d pend=%0d want acc=%0d pend=0",
               acc, exp_q.size(), total);
    else
      passes++;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic push_req(input logic [1:0] t, input logic [63:0] a,
                          input logic [3:0] id, input logic [63:0] d);
    req_t r;
    r.t = t; r.a = a; r.id = id; r.d = d;
    stim_q.push_back(r);
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_type  = '0;
    bus.req_addr  = '0;
    bus.req_id    = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL in_reset: got rdy=%b vld=%b want 0 0",
               bus.req_ready, bus.rsp_valid);
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_type !== bus_read_response || bus.rsp_id !== 4'd0 ||
        bus.rsp_payload !== 64'd0)
      $display("FAIL after_reset: got rdy=%b vld=%b t=%0d id=%0d p=%h want 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_type,
               bus.rsp_id, bus.rsp_payload);
    else passes++;
  endtask

  task automatic test_preload;
    for (int i = 0; i < 16; i++)
      push_req(2'd1, 64'(i * 8), 4'(i),
               (i == 2) ? 64'hDEAD_BEEF_0000_0001
                        : {$urandom, $urandom});
    run(0, 0, 0);
  endtask

  task automatic test_single_read;
    int lat = 0;
    bus.req_valid = 1'b1;
    bus.req_type  = 2'd0;
    bus.req_addr  = 64'h10;
    bus.req_id    = 4'd3;
    checks++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL single_ready: got %b want 1", bus.req_ready);
    else passes++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 1 + RLAT)
      $display("FAIL single_latency: got %0d want %0d", lat, 1 + RLAT);
    else passes++;
    checks++;
    if (bus.rsp_type !== bus_read_response || bus.rsp_id !== 4'd3 ||
        bus.rsp_payload !== 64'hDEAD_BEEF_0000_0001)
      $display("FAIL single_data: got t=%0d id=%0d p=%h want 0 3 deadbeef00000001",
               bus.rsp_type, bus.rsp_id, bus.rsp_payload);
    else passes++;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL single_drop: got vld=%b want 0", bus.rsp_valid);
    else passes++;
  endtask

  task automatic test_write_then_read;
    push_req(2'd1, 64'h18, 4'd1, 64'h1234);
    push_req(2'd0, 64'h1F, 4'd2, 64'h0);
    run(0, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++)
      push_req(2'd0, 64'(i * 8), 4'(10 + i), 64'h0);
    run(3, 20, 0);
    checks++;
    if (acc_rel !== 5 || rdy_rel !== 1'b0)
      $display("FAIL b2b_full: got acc=%0d rdy=%b want 5 0",
               acc_rel, rdy_rel);
    else passes++;
  endtask

  task automatic test_out_of_range;
    push_req(2'd0, 64'h2000, 4'd4, 64'h0);
    push_req(2'd1, 64'h2010, 4'd5, 64'hFFFF_0000_FFFF_0000);
    push_req(2'd0, 64'h10, 4'd6, 64'h0);
    push_req(2'd3, 64'h10, 4'd7, 64'h0);
    run(0, 0, 0);
  endtask

  task automatic test_ready_toggle;
    for (int i = 0; i < 8; i++)
      push_req(2'd0, 64'(i * 8 + 3), 4'(i), 64'h0);
    run(1, 0, 0);
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 1'b1;
      bus.req_type  = (k == 2) ? 2'd1 : 2'd0;
      bus.req_addr  = (k == 2) ? 64'h30 : 64'h28;
      bus.req_id    = 4'(9 + k);
      bus.req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL mid_reset: got rdy=%b vld=%b want 0 0",
               bus.req_ready, bus.rsp_valid);
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0)
      $display("FAIL mid_no_rsp: got %0d valid cycles want 0", seen);
    else passes++;
    push_req(2'd0, 64'h28, 4'd12, 64'h0);
    push_req(2'd0, 64'h30, 4'd13, 64'h0);
    run(0, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++) begin
      req_t r;
      int unsigned sel;
      sel  = $urandom_range(0, 9);
      r.id = 4'(i);
      r.d  = {$urandom, $urandom};
      r.a  = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      if (sel <= 4) r.t = 2'd0;
      else if (sel <= 7) r.t = 2'd1;
      else if (sel == 8) r.t = 2'($urandom_range(2, 3));
      else begin
        r.t = 2'($urandom_range(0, 1));
        r.a = r.a | (64'd1 << $urandom_range(13, 63));
      end
      stim_q.push_back(r);
    end
    run(2, 0, 30);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_single_read();
    test_write_then_read();
    test_back_to_back();
    test_out_of_range();
    test_ready_toggle();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
